spi_flash_arbiter: RTL and testbench
====================================

# spi_flash_arbiter

Shares the single application SPI flash port (clock, COPI, CIPO, chip select) between several SPI hosts inside `sonata_system`, for example the software-visible SPI block and a boot-time copy engine. Grants are whole transactions. Arbitration is round-robin, and a guaranteed chip-select idle gap separates consecutive owners. An optional hold watchdog revokes a stuck owner. The block sits between the SPI host instances and the flash pads, ahead of the fixed WP_N/HOLD_N tie-offs.

## Interface
Parameters:
- `NumReq`, default 2: number of requesting SPI hosts; range 2..8.
- `CsGapCycles`, default 4: minimum number of `clk_i` cycles that `spi_cs_no` is held high between two grants; 0 means no gap.
- `MaxHoldCycles`, default 0: maximum number of cycles in ACTIVE before forced revocation; 0 disables the watchdog.

Ports:
- `clk_i`  in  1  system clock (single clock domain).
- `rst_ni`  in  1  reset; synchronous, active-low.
- `req_i`  in  NumReq  per-host request; held high for the whole transaction.
- `gnt_o`  out  NumReq  one-hot grant, registered.
- `sck_i`  in  NumReq  per-host SPI clock.
- `copi_i`  in  NumReq  per-host COPI.
- `cs_ni`  in  NumReq  per-host chip select, active-low.
- `cipo_o`  out  NumReq  CIPO returned to each host; 0 for any host not granted.
- `spi_sck_o`  out  1  flash clock.
- `spi_copi_o`  out  1  flash COPI.
- `spi_cs_no`  out  1  flash chip select, active-low.
- `spi_cipo_i`  in  1  flash CIPO.
- `timeout_o`  out  1  one-cycle pulse when the watchdog revokes a grant.
- `timeout_id_o`  out  $clog2(NumReq)  index of the revoked host; holds its value until the next timeout.

## Operation
- The FSM has three states: IDLE, ACTIVE and GAP. The reset state is IDLE.
- Reset values: `gnt_o`=0, `spi_cs_no`=1, `spi_sck_o`=0, `spi_copi_o`=0, `cipo_o`=0, `timeout_o`=0, `timeout_id_o`=0, round-robin pointer=0, mask=0, counters=0.
- **IDLE:** the block considers the eligible requests `req_i & ~mask`. The winner is the first eligible index at or after the pointer, searching upward with wrap-around. On a win:
  - set `gnt_o` to the winner's one-hot value;
  - set the pointer to winner+1 modulo NumReq;
  - go to ACTIVE.
- **ACTIVE:** the outputs pass through from the granted host:
  - `spi_sck_o`=`sck_i[g]`, `spi_copi_o`=`copi_i[g]`, `spi_cs_no`=`cs_ni[g]`;
  - `cipo_o[g]`=`spi_cipo_i`.
- **Release:** the grant is released when `req_i[g]`=0 and `cs_ni[g]`=1 in the same cycle. Dropping `req_i` while `cs_ni[g]`=0 does not release; the grant is kept until CS goes high. On release, go to GAP, or straight to IDLE if CsGapCycles=0.
- **Watchdog:** when MaxHoldCycles>0, the hold counter increments each ACTIVE cycle and clears on entry to ACTIVE. When the counter reaches MaxHoldCycles, the block:
  - revokes the grant;
  - pulses `timeout_o`;
  - sets `timeout_id_o`=g;
  - sets `mask[g]`;
  - goes to GAP.
  The counter saturates and is $clog2(MaxHoldCycles+1) bits wide.
- **GAP:** `gnt_o`=0, `spi_cs_no`=1, `spi_sck_o`=0 and `spi_copi_o`=0. The gap counter counts CsGapCycles cycles, then the FSM goes to IDLE.
- **Mask:** `mask[i]` clears in any cycle where `req_i[i]`=0, so a revoked host must drop its request before it can win again.
- **Outside ACTIVE:** in IDLE and GAP the flash-side outputs sit at their reset values and `cipo_o`=0.
- **Reset mid-transaction:** asserting `rst_ni` during ACTIVE forces the reset values on the next edge, including `spi_cs_no`=1. No gap is enforced after reset.

## Timing
- **Grant latency:** `req_i` seen high in IDLE at edge t gives `gnt_o` high from edge t+1. The data mux is combinational from the registered grant, so the granted host's `cs_ni` appears on `spi_cs_no` in the same cycle it drives it.
- **Release:** the release condition at edge t deasserts `gnt_o` from t+1. `spi_cs_no` is then high for exactly CsGapCycles cycles in GAP. The earliest next grant is at t+1+CsGapCycles+1, one cycle in IDLE for arbitration.
- **Back-to-back by one host:** the same rules apply. If the other host is also requesting, the pointer gives it priority.
- **Simultaneous requests in IDLE:** the pointer decides the winner. After reset, host 0 wins.
- **Release and timeout in the same cycle:** release takes priority; `timeout_o` stays 0.
- **Full CIPO path:** `spi_cipo_i` to `cipo_o` is combinational, so the flash sampling timing is unchanged from a direct connection.

## Test plan
- **Single host:** NumReq=2, host 0 requests at cycle 10 → `gnt_o`=2'b01 at 11. Drive 8 SCK edges with `cs_ni[0]` low, then raise `cs_ni[0]` and drop `req_i[0]` at 30 → `gnt_o`=0 at 31. `spi_cs_no` is high for cycles 31..34, IDLE at 35.
- **Round-robin:** both hosts request continuously for 6 transactions → grants go 0,1,0,1,0,1, each separated by a ≥4-cycle CS-high gap.
- **Early request drop:** host 1 drops `req_i` while `cs_ni[1]`=0 → grant held. The grant releases one cycle after `cs_ni[1]` rises.
- **Watchdog:** MaxHoldCycles=16, host 0 holds `cs_ni` low indefinitely →
  - on cycle 16 of ACTIVE, `timeout_o` pulses once with `timeout_id_o`=0 and `spi_cs_no` goes high;
  - host 1 is granted after the gap;
  - host 0 is not granted again until it drops `req_i`.
- **Isolation:** while host 1 is granted, toggle `sck_i[0]`/`copi_i[0]`/`cs_ni[0]` → flash pins are unaffected and `cipo_o[0]`=0 throughout.
- **Reset:** assert `rst_ni`=0 for one cycle mid-ACTIVE → the next cycle shows `spi_cs_no`=1 and `gnt_o`=0. A subsequent simultaneous request grants host 0.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// Round-robin, whole-transaction arbiter sharing one SPI flash port between several SPI hosts.
// A chip-select idle gap separates consecutive owners; an optional hold watchdog revokes a
// host that keeps the flash for too long.
module spi_flash_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned CsGapCycles   = 4,
    parameter int unsigned MaxHoldCycles = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_i,
    output logic [NumReq-1:0]         gnt_o,
    input  logic [NumReq-1:0]         sck_i,
    input  logic [NumReq-1:0]         copi_i,
    input  logic [NumReq-1:0]         cs_ni,
    output logic [NumReq-1:0]         cipo_o,
    output logic                      spi_sck_o,
    output logic                      spi_copi_o,
    output logic                      spi_cs_no,
    input  logic                      spi_cipo_i,
    output logic                      timeout_o,
    output logic [$clog2(NumReq)-1:0] timeout_id_o
);

    localparam int unsigned IdxW  = $clog2(NumReq);
    localparam int unsigned HoldW = (MaxHoldCycles > 0) ? $clog2(MaxHoldCycles + 1) : 1;
    localparam int unsigned GapW  = (CsGapCycles > 0) ? $clog2(CsGapCycles + 1) : 1;
    localparam bit          WdEn  = (MaxHoldCycles > 0);

    localparam logic [HoldW-1:0] HoldMax = HoldW'(MaxHoldCycles);
    localparam logic [GapW-1:0]  GapLast = GapW'((CsGapCycles > 0) ? CsGapCycles - 1 : 0);

    typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

    // With no gap configured, a finished owner hands straight back to arbitration.
    localparam state_e StAfter = (CsGapCycles == 0) ? StIdle : StGap;

    state_e            state_q, state_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [NumReq-1:0] mask_q, mask_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              timeout_q, timeout_d;
    logic [IdxW-1:0]   timeout_id_q, timeout_id_d;

    logic [NumReq-1:0] eligible;
    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   cand;
    logic              release_req;
    logic [HoldW-1:0]  hold_inc;

    function automatic logic [IdxW-1:0] wrap_idx(input int unsigned v);
        return IdxW'(v % NumReq);
    endfunction

    // Pick the first eligible requester at or after the pointer, wrapping around.
    always_comb begin
        eligible  = req_i & ~mask_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = wrap_idx(32'(ptr_q) + k);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Release needs both the request dropped and the host's CS back high.
    always_comb begin
        release_req = ~(|(gnt_q & req_i)) & (|(gnt_q & cs_ni));
        hold_inc    = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + HoldW'(1);
    end

    // Next-state logic for the grant FSM, counters, mask and watchdog report.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gnt_idx_d    = gnt_idx_q;
        ptr_d        = ptr_q;
        mask_d       = mask_q & req_i;
        hold_cnt_d   = hold_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d    = StActive;
                    gnt_d      = NumReq'(1) << win_idx;
                    gnt_idx_d  = win_idx;
                    ptr_d      = wrap_idx(32'(win_idx) + 1);
                    hold_cnt_d = '0;
                end
            end
            StActive: begin
                if (release_req) begin
                    state_d   = StAfter;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_inc;
                    if (WdEn && (hold_inc == HoldMax)) begin
                        state_d           = StAfter;
                        gnt_d             = '0;
                        gap_cnt_d         = '0;
                        timeout_d         = 1'b1;
                        timeout_id_d      = gnt_idx_q;
                        mask_d[gnt_idx_q] = 1'b1;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            gnt_idx_q    <= '0;
            ptr_q        <= '0;
            mask_q       <= '0;
            hold_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_idx_q    <= gnt_idx_d;
            ptr_q        <= ptr_d;
            mask_q       <= mask_d;
            hold_cnt_q   <= hold_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    // Data mux steered by the registered one-hot grant; all-zero grant parks the pads idle.
    always_comb begin
        spi_sck_o  = |(gnt_q & sck_i);
        spi_copi_o = |(gnt_q & copi_i);
        spi_cs_no  = ~(|(gnt_q & ~cs_ni));
        cipo_o     = gnt_q & {NumReq{spi_cipo_i}};
    end

    assign gnt_o        = gnt_q;
    assign timeout_o    = timeout_q;
    assign timeout_id_o = timeout_id_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench for spi_flash_arbiter: randomized host agents against a behavioural
// model that tracks owner, remaining gap cycles, pointer, mask and hold time as integers.
module tb_spi_flash_arbiter;

    localparam int N    = 2;
    localparam int GAP  = 4;
    localparam int MAXH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, gnt, sck, copi, cs_n, cipo;
    logic       spi_sck, spi_copi, spi_cs_n, spi_cipo, to;
    logic [0:0] to_id;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model state
    int       m_owner, m_gap, m_ptr, m_hold, m_to_id;
    bit [1:0] m_mask;
    bit       m_to;

    // Host agent state
    int ag_len [N];
    bit ag_on  [N];
    bit ag_stuck [N];
    bit ag_drop [N];
    bit ag_early, ag_noisy;

    // Observations
    int         glog[$];
    logic [1:0] prev_gnt;
    int         to_cnt;
    int         to_glog_idx;

    always #5 clk = ~clk;

    spi_flash_arbiter #(
        .NumReq       (N),
        .CsGapCycles  (GAP),
        .MaxHoldCycles(MAXH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .sck_i       (sck),
        .copi_i      (copi),
        .cs_ni       (cs_n),
        .cipo_o      (cipo),
        .spi_sck_o   (spi_sck),
        .spi_copi_o  (spi_copi),
        .spi_cs_no   (spi_cs_n),
        .spi_cipo_i  (spi_cipo),
        .timeout_o   (to),
        .timeout_id_o(to_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_gap   = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_mask  = '0;
        m_to    = 1'b0;
        m_to_id = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit [1:0] nmask;
        bit       won;
        int       o, i;
        if (!rst_n) begin
            m_reset();
            return;
        end
        nmask = m_mask & req;
        m_to  = 1'b0;
        o     = m_owner;
        if (o >= 0) begin
            if (!req[o] && cs_n[o]) begin
                m_owner = -1;
                m_gap   = GAP;
            end else begin
                m_hold++;
                if (MAXH > 0 && m_hold >= MAXH) begin
                    m_to     = 1'b1;
                    m_to_id  = o;
                    nmask[o] = 1'b1;
                    m_owner  = -1;
                    m_gap    = GAP;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            won = 1'b0;
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (!won && req[i] && !m_mask[i]) begin
                    won     = 1'b1;
                    m_owner = i;
                    m_ptr   = (i + 1) % N;
                    m_hold  = 0;
                end
            end
        end
        m_mask = nmask;
    endtask

    task automatic check_outputs();
        logic [1:0] e_gnt, e_cipo;
        logic       e_cs, e_sck, e_copi;
        e_gnt  = '0;
        e_cipo = '0;
        e_cs   = 1'b1;
        e_sck  = 1'b0;
        e_copi = 1'b0;
        if (m_owner >= 0) begin
            e_gnt[m_owner]  = 1'b1;
            e_cs            = cs_n[m_owner];
            e_sck           = sck[m_owner];
            e_copi          = copi[m_owner];
            e_cipo[m_owner] = spi_cipo;
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("spi_cs_n", 32'(spi_cs_n), 32'(e_cs));
        chk("spi_sck", 32'(spi_sck), 32'(e_sck));
        chk("spi_copi", 32'(spi_copi), 32'(e_copi));
        chk("cipo", 32'(cipo), 32'(e_cipo));
        chk("timeout", 32'(to), 32'(m_to));
        chk("timeout_id", 32'(to_id), 32'(m_to_id));
    endtask

    // Host behaviour: request, hold CS low for ag_len cycles once granted, then release.
    task automatic drive();
        for (int h = 0; h < N; h++) begin
            sck[h]  = 1'($urandom);
            copi[h] = 1'($urandom);
            if (!ag_on[h] || ag_drop[h]) begin
                req[h]  = 1'b0;
                cs_n[h] = ag_noisy ? 1'($urandom) : 1'b1;
            end else if (m_owner == h) begin
                if (ag_len[h] > 0) begin
                    cs_n[h] = 1'b0;
                    req[h]  = !(ag_early && ag_len[h] <= 2);
                    if (!ag_stuck[h]) ag_len[h]--;
                end else begin
                    cs_n[h]   = 1'b1;
                    req[h]    = 1'b0;
                    ag_len[h] = $urandom_range(3, 10);
                end
            end else begin
                req[h]  = 1'b1;
                cs_n[h] = ag_noisy ? 1'($urandom) : 1'b1;
            end
        end
        spi_cipo = 1'($urandom);
    endtask

    task automatic tick();
        drive();
        #1;
        check_outputs();
        if (gnt !== prev_gnt && gnt !== 2'b00) glog.push_back(gnt[1] ? 1 : 0);
        prev_gnt = gnt;
        if (to === 1'b1) begin
            to_cnt++;
            if (to_glog_idx < 0) to_glog_idx = glog.size();
        end
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic agents_off();
        for (int h = 0; h < N; h++) begin
            ag_on[h]    = 1'b0;
            ag_stuck[h] = 1'b0;
            ag_drop[h]  = 1'b0;
            ag_len[h]   = 6;
        end
        ag_early = 1'b0;
        ag_noisy = 1'b0;
    endtask

    initial begin
        int n0, n1;
        bit found;
        agents_off();
        prev_gnt    = 2'b00;
        to_cnt      = 0;
        to_glog_idx = -1;

        // First reset edge brings the DUT out of X; check from the second cycle on.
        rst_n = 1'b0;
        @(negedge clk);
        drive();
        m_reset();
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Round-robin from reset: both hosts keep requesting.
        glog.delete();
        ag_on[0] = 1'b1;
        ag_on[1] = 1'b1;
        for (int i = 0; i < 300 && glog.size() < 6; i++) tick();
        chk("rr_count", 32'(glog.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) chk("rr_order", 32'(i < glog.size() ? glog[i] : 99), 32'(i % 2));
        agents_off();
        repeat (15) tick();

        // Single host, 8 cycles of CS low.
        ag_on[0]  = 1'b1;
        ag_len[0] = 8;
        repeat (30) tick();
        agents_off();
        repeat (10) tick();

        // Early request drop while CS is still low.
        ag_on[1] = 1'b1;
        ag_early = 1'b1;
        repeat (50) tick();
        agents_off();
        repeat (10) tick();

        // Watchdog with isolation noise: host 0 never releases CS.
        glog.delete();
        to_cnt       = 0;
        to_glog_idx  = -1;
        ag_noisy     = 1'b1;
        ag_on[0]     = 1'b1;
        ag_stuck[0]  = 1'b1;
        ag_len[0]    = 5;
        ag_on[1]     = 1'b1;
        repeat (100) tick();
        chk("wd_pulses", 32'(to_cnt), 32'd1);
        n0 = 0;
        n1 = 0;
        if (to_glog_idx >= 0) begin
            for (int i = to_glog_idx; i < glog.size(); i++) begin
                if (glog[i] == 0) n0++;
                else n1++;
            end
        end
        chk("wd_no_regrant_0", 32'(n0), 32'd0);
        chk("wd_host1_after", 32'(n1 > 0), 32'd1);
        // Host 0 drops its request, which unmasks it.
        ag_drop[0]  = 1'b1;
        ag_stuck[0] = 1'b0;
        repeat (2) tick();
        ag_drop[0] = 1'b0;
        repeat (60) tick();
        agents_off();
        repeat (10) tick();

        // Reset in the middle of a transaction.
        ag_on[0]  = 1'b1;
        ag_on[1]  = 1'b1;
        ag_len[0] = 10;
        ag_len[1] = 10;
        found     = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = (m_owner >= 0);
        end
        chk("rst_wait_grant", 32'(found), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        glog.delete();
        prev_gnt = 2'b00;
        repeat (5) tick();
        chk("post_rst_first", 32'(glog.size() > 0 ? glog[0] : 99), 32'd0);

        // Randomized traffic with occasional mode changes and resets.
        for (int i = 0; i < 1500; i++) begin
            if (i % 40 == 0) begin
                for (int h = 0; h < N; h++) begin
                    ag_on[h]    = 1'($urandom);
                    ag_stuck[h] = ($urandom_range(0, 5) == 0);
                    if (ag_stuck[h]) ag_len[h] = 4;
                end
                ag_early = 1'($urandom);
                ag_noisy = 1'($urandom);
            end
            for (int h = 0; h < N; h++) ag_drop[h] = ($urandom_range(0, 30) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
